grid_move_resolver: RTL

//  Registered successor to the combinational collision check. Holds the player position and resolves

---
 rtl/grid_move_resolver.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/grid_move_resolver.sv
// grid_move_resolver
//   Holds the player position and resolves move requests against NUM_MAPS
//   wall maps that can be loaded at runtime. Valid/ready handshake on both
//   the request side (input decode) and the response side (renderer / game FSM).
//
//   Each move takes three steps:
//     accept -> LOOKUP -> RESP
//   The response is valid two cycles after accept. With rsp_ready held high,
//   one move completes every three cycles.
//
// Ports
//   clk, resetn             clock; asynchronous active-low reset
//   wr_en/wr_map/wr_row/wr_data
//                           Map row write. In wr_data the MSB is column 0,
//                           1 = wall. Out-of-range map or row is ignored.
//   pos_load/_x/_y          Teleport. Honoured only in IDLE, and takes
//                           priority over a request.
//   req_valid/req_ready     Move request handshake.
//   req_move                100 right, 001 up, 010 left, 011 down,
//                           any other code = stay.
//   req_map                 Map checked for this request.
//   rsp_valid/rsp_ready     Response handshake. The response is held
//                           until accepted.
//   rsp_x/rsp_y             Current position.
//   rsp_blocked             Move rejected (wall, grid edge or bad map).
//   rsp_exit                Unblocked move landed on a border cell.
//                           Driven only when EXIT_DETECT_EN is defined;
//                           otherwise tied 0.
//
// Optional feature macro: EXIT_DETECT_EN
module grid_move_resolver #(
  parameter int GRID_W   = 20,
  parameter int GRID_H   = 15,
  parameter int COORD_W  = 5,
  parameter int NUM_MAPS = 4,
  parameter int MAP_W    = 2,
  parameter int START_X  = 8,
  parameter int START_Y  = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wr_en,
  input  logic [MAP_W-1:0]   wr_map,
  input  logic [COORD_W-1:0] wr_row,
  input  logic [GRID_W-1:0]  wr_data,
  input  logic               pos_load,
  input  logic [COORD_W-1:0] pos_load_x,
  input  logic [COORD_W-1:0] pos_load_y,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_move,
  input  logic [MAP_W-1:0]   req_map,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [COORD_W-1:0] rsp_x,
  output logic [COORD_W-1:0] rsp_y,
  output logic               rsp_blocked,
  output logic               rsp_exit
);

  localparam logic [COORD_W-1:0] ZERO_C    = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE_C     = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX_C   = COORD_W'(GRID_H - 1);
  localparam logic [MAP_W:0]     MAP_LIM_C = (MAP_W + 1)'(NUM_MAPS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [GRID_W-1:0]  map_mem_r [NUM_MAPS][GRID_H];
  logic [COORD_W-1:0] pos_x_r;
  logic [COORD_W-1:0] pos_y_r;
  logic [COORD_W-1:0] tgt_x_r;
  logic [COORD_W-1:0] tgt_y_r;
  logic               edge_blk_r;
  logic               stay_r;
  logic [MAP_W-1:0]   map_sel_r;
  logic               rsp_valid_r;
  logic               rsp_blocked_r;
  logic               rsp_exit_r;

  logic [COORD_W-1:0] tgt_x_s;
  logic [COORD_W-1:0] tgt_y_s;
  logic               edge_blk_s;
  logic               stay_s;
  logic [GRID_W-1:0]  row_s;
  logic               wall_s;
  logic               blocked_s;
  logic               exit_s;

  assign req_ready   = (state_r == ST_IDLE) & ~pos_load;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_x       = pos_x_r;
  assign rsp_y       = pos_y_r;
  assign rsp_blocked = rsp_blocked_r;
  assign rsp_exit    = rsp_exit_r;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. A teleport in IDLE wins over a pending request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = (req_valid && !pos_load) ? ST_LOOKUP : ST_IDLE;
      ST_LOOKUP: state_nxt_s = ST_RESP;
      ST_RESP:   state_nxt_s = rsp_ready ? ST_IDLE : ST_RESP;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Target computation at accept time. At a grid edge the target stays at
  // the current position, so the later map read never leaves the grid.
  always_comb begin
    tgt_x_s    = pos_x_r;
    tgt_y_s    = pos_y_r;
    edge_blk_s = 1'b0;
    stay_s     = 1'b0;
    case (req_move)
      3'b100: begin
        if (pos_x_r == X_MAX_C) edge_blk_s = 1'b1;
        else                    tgt_x_s    = pos_x_r + ONE_C;
      end
      3'b010: begin
        if (pos_x_r == ZERO_C) edge_blk_s = 1'b1;
        else                   tgt_x_s    = pos_x_r - ONE_C;
      end
      3'b001: begin
        if (pos_y_r == ZERO_C) edge_blk_s = 1'b1;
        else                   tgt_y_s    = pos_y_r - ONE_C;
      end
      3'b011: begin
        if (pos_y_r == Y_MAX_C) edge_blk_s = 1'b1;
        else                    tgt_y_s    = pos_y_r + ONE_C;
      end
      default: stay_s = 1'b1;
    endcase
  end

  // Map lookup during LOOKUP. Rows are selected by compare, not by array
  // index, so an out-of-range map/row reads as open; bad maps are rejected
  // separately through map_ok.
  always_comb begin
    row_s  = {GRID_W{1'b0}};
    wall_s = 1'b0;
    exit_s = 1'b0;
    for (int m = 0; m < NUM_MAPS; m++) begin
      for (int r = 0; r < GRID_H; r++) begin
        row_s = ((map_sel_r == MAP_W'(m)) && (tgt_y_r == COORD_W'(r))) ?
                map_mem_r[m][r] : row_s;
      end
    end
    for (int c = 0; c < GRID_W; c++) begin
      wall_s = (tgt_x_r == COORD_W'(c)) ? row_s[GRID_W-1-c] : wall_s;
    end
    blocked_s = ~stay_r & (edge_blk_r | ({1'b0, map_sel_r} >= MAP_LIM_C) | wall_s);
`ifdef EXIT_DETECT_EN
    exit_s = ~blocked_s & ~stay_r &
             ((tgt_x_r == ZERO_C) | (tgt_x_r == X_MAX_C) |
              (tgt_y_r == ZERO_C) | (tgt_y_r == Y_MAX_C));
`else
    exit_s = 1'b0;
`endif
  end

  // Position, latched request and registered response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_x_r       <= COORD_W'(START_X);
      pos_y_r       <= COORD_W'(START_Y);
      tgt_x_r       <= COORD_W'(START_X);
      tgt_y_r       <= COORD_W'(START_Y);
      edge_blk_r    <= 1'b0;
      stay_r        <= 1'b0;
      map_sel_r     <= {MAP_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_blocked_r <= 1'b0;
      rsp_exit_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pos_load) begin
            pos_x_r <= pos_load_x;
            pos_y_r <= pos_load_y;
          end else if (req_valid) begin
            tgt_x_r    <= tgt_x_s;
            tgt_y_r    <= tgt_y_s;
            edge_blk_r <= edge_blk_s;
            stay_r     <= stay_s;
            map_sel_r  <= req_map;
          end
        end
        ST_LOOKUP: begin
          rsp_valid_r   <= 1'b1;
          rsp_blocked_r <= blocked_s;
          rsp_exit_r    <= exit_s;
          if (!blocked_s) begin
            pos_x_r <= tgt_x_r;
            pos_y_r <= tgt_y_r;
          end
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid_r <= 1'b0;
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

  // Wall map storage. A write lands on the edge, so a same-edge LOOKUP
  // read still sees the old row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int m = 0; m < NUM_MAPS; m++) begin
        for (int r = 0; r < GRID_H; r++) begin
          map_mem_r[m][r] <= {GRID_W{1'b0}};
        end
      end
    end else begin
      for (int m = 0; m < NUM_MAPS; m++) begin
        for (int r = 0; r < GRID_H; r++) begin
          if (wr_en && (wr_map == MAP_W'(m)) && (wr_row == COORD_W'(r))) begin
            map_mem_r[m][r] <= wr_data;
          end
        end
      end
    end
  end

endmodule
